// File: rtl/multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// multicycle_control_unit
// Moore FSM controller for the multi-cycle RV32I datapath. Each instruction is
// stepped through fetch / decode / execute / memory / writeback over a shared
// ALU and a unified memory. Memory accesses use a req/ready handshake guarded
// by a wait watchdog. Illegal opcodes and memory timeouts park the FSM in a
// sticky TRAP state until reset. Retired instructions are pulsed and counted.
//
// Ports
//   i_clk             clock, all state changes on the rising edge
//   i_reset           synchronous active-high reset
//   i_opcode[6:0]     instr[6:0] from the instruction register
//   i_branch_taken    branch comparator result
//   i_mem_ready       memory completes the current request this cycle
//   o_mem_req         memory access request
//   o_mem_we          memory write enable (meaningful with o_mem_req)
//   o_addr_sel        memory address: 0=PC, 1=ALUOut
//   o_ir_write        load IR and latch oldPC
//   o_pc_write        PC update strobe
//   o_reg_write       register file write
//   o_alu_src_a[1:0]  00=PC, 01=oldPC, 10=rs1
//   o_alu_src_b[1:0]  00=rs2, 01=imm, 10=constant 4
//   o_alu_op[1:0]     00=add, 01=branch compare, 10=R funct, 11=I funct
//   o_result_src[1:0] 00=ALUOut, 01=mem data, 10=ALU result
//   o_state[3:0]      current state encoding (debug)
//   o_trap            sticky fault flag
//   o_trap_cause      0=illegal opcode, 1=memory timeout
//   o_instr_retired   one-cycle pulse per completed instruction
//   o_retired_count   running retired-instruction count (wraps)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 computed, IR/PC load on ready
// DECODE   | ALUOut <= oldPC + imm (branch/jump target), dispatch
// MEMADR   | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  | load access at ALUOut, wait for ready
// MEMWB    | write load data to rd, retire
// MEMWRITE | store access at ALUOut, retire on ready
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALUOut to rd, retire
// BRANCH   | compare rs1/rs2, PC <= target when taken, retire
// JUMP     | PC <= oldPC + imm (jal)
// JALR     | PC <= rs1 + imm (jalr)
// LINK     | rd <= oldPC + 4, retire
// TRAP     | fault, all strobes low, held until reset
// -----------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [6:0]              i_opcode,
    input  logic                    i_branch_taken,
    input  logic                    i_mem_ready,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic                    o_addr_sel,
    output logic                    o_ir_write,
    output logic                    o_pc_write,
    output logic                    o_reg_write,
    output logic [1:0]              o_alu_src_a,
    output logic [1:0]              o_alu_src_b,
    output logic [1:0]              o_alu_op,
    output logic [1:0]              o_result_src,
    output logic [3:0]              o_state,
    output logic                    o_trap,
    output logic                    o_trap_cause,
    output logic                    o_instr_retired,
    output logic [RETIRE_CNT_W-1:0] o_retired_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    // Counter only needs to reach MEM_TIMEOUT-1.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t                  r_state;
    logic [WAIT_W-1:0]       r_wait_cnt;
    logic                    r_trap;
    logic                    r_trap_cause;
    logic [RETIRE_CNT_W-1:0] r_retired_count;

    logic w_mem_state;
    logic w_timeout;
    logic w_retire;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                         (r_state == S_MEMWRITE);

    // A ready in the last allowed cycle completes the transfer instead.
    assign w_timeout = (MEM_TIMEOUT > 0) && w_mem_state && !i_mem_ready &&
                       (r_wait_cnt == WAIT_LAST);

    assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                      (r_state == S_BRANCH) || (r_state == S_LINK) ||
                      ((r_state == S_MEMWRITE) && i_mem_ready);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= S_FETCH;
            r_wait_cnt      <= '0;
            r_trap          <= 1'b0;
            r_trap_cause    <= 1'b0;
            r_retired_count <= '0;
        end else begin
            if (w_retire)
                r_retired_count <= r_retired_count + 1'b1;

            // Waiting is the only way to stay in a memory state, so clearing
            // on ready/timeout also covers the clear-on-state-change rule.
            if ((MEM_TIMEOUT > 0) && w_mem_state && !i_mem_ready && !w_timeout)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            else
                r_wait_cnt <= '0;

            case (r_state)
                S_FETCH: begin
                    if (i_mem_ready) begin
                        r_state <= S_DECODE;
                    end else if (w_timeout) begin
                        r_state      <= S_TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= 1'b1;
                    end
                end
                S_DECODE: begin
                    case (i_opcode)
                        7'b0000011,
                        7'b0100011: r_state <= S_MEMADR;
                        7'b0110011: r_state <= S_EXECR;
                        7'b0010011: r_state <= S_EXECI;
                        7'b1100011: r_state <= S_BRANCH;
                        7'b1101111: r_state <= S_JUMP;
                        7'b1100111: r_state <= S_JALR;
                        default: begin
                            r_state      <= S_TRAP;
                            r_trap       <= 1'b1;
                            r_trap_cause <= 1'b0;
                        end
                    endcase
                end
                S_MEMADR:
                    r_state <= i_opcode[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD, S_MEMWRITE: begin
                    if (i_mem_ready) begin
                        r_state <= (r_state == S_MEMREAD) ? S_MEMWB : S_FETCH;
                    end else if (w_timeout) begin
                        r_state      <= S_TRAP;
                        r_trap       <= 1'b1;
                        r_trap_cause <= 1'b1;
                    end
                end
                S_MEMWB, S_ALUWB, S_BRANCH, S_LINK:
                    r_state <= S_FETCH;
                S_EXECR, S_EXECI:
                    r_state <= S_ALUWB;
                S_JUMP, S_JALR:
                    r_state <= S_LINK;
                S_TRAP:
                    r_state <= S_TRAP;
                default: begin
                    r_state      <= S_TRAP;
                    r_trap       <= 1'b1;
                    r_trap_cause <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_mem_req       = 1'b0;
        o_mem_we        = 1'b0;
        o_addr_sel      = 1'b0;
        o_ir_write      = 1'b0;
        o_pc_write      = 1'b0;
        o_reg_write     = 1'b0;
        o_alu_src_a     = 2'b00;
        o_alu_src_b     = 2'b00;
        o_alu_op        = 2'b00;
        o_result_src    = 2'b00;
        o_instr_retired = w_retire;

        case (r_state)
            S_FETCH: begin
                o_mem_req    = 1'b1;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                o_ir_write   = i_mem_ready;
                o_pc_write   = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                o_mem_req  = 1'b1;
                o_addr_sel = 1'b1;
            end
            S_MEMWB: begin
                o_reg_write  = 1'b1;
                o_result_src = 2'b01;
            end
            S_MEMWRITE: begin
                o_mem_req  = 1'b1;
                o_mem_we   = 1'b1;
                o_addr_sel = 1'b1;
            end
            S_EXECR: begin
                o_alu_src_a = 2'b10;
                o_alu_op    = 2'b10;
            end
            S_EXECI: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
                o_alu_op    = 2'b11;
            end
            S_ALUWB: begin
                o_reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a = 2'b10;
                o_alu_op    = 2'b01;
                o_pc_write  = i_branch_taken;
            end
            S_JUMP: begin
                o_alu_src_a  = 2'b01;
                o_alu_src_b  = 2'b01;
                o_result_src = 2'b10;
                o_pc_write   = 1'b1;
            end
            S_JALR: begin
                o_alu_src_a  = 2'b10;
                o_alu_src_b  = 2'b01;
                o_result_src = 2'b10;
                o_pc_write   = 1'b1;
            end
            S_LINK: begin
                o_alu_src_a  = 2'b01;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                o_reg_write  = 1'b1;
            end
            default: ;
        endcase

        // Reset takes effect on the outputs immediately, not at the edge.
        if (i_reset) begin
            o_mem_req       = 1'b0;
            o_mem_we        = 1'b0;
            o_addr_sel      = 1'b0;
            o_ir_write      = 1'b0;
            o_pc_write      = 1'b0;
            o_reg_write     = 1'b0;
            o_alu_src_a     = 2'b00;
            o_alu_src_b     = 2'b00;
            o_alu_op        = 2'b00;
            o_result_src    = 2'b00;
            o_instr_retired = 1'b0;
        end
    end

    assign o_state         = r_state;
    assign o_trap          = r_trap;
    assign o_trap_cause    = r_trap_cause;
    assign o_retired_count = r_retired_count;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_unit
// Directed bench for multicycle_control_unit with MEM_TIMEOUT=4. Each cycle
// checks the state, a strobe bundle {req,we,addr_sel,ir_write,pc_write,
// reg_write,retired} and a select bundle {a,b,op,result_src} against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_multicycle_control_unit;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [6:0]  i_opcode;
    logic        i_branch_taken;
    logic        i_mem_ready;
    logic        o_mem_req, o_mem_we, o_addr_sel, o_ir_write, o_pc_write;
    logic        o_reg_write, o_trap, o_trap_cause, o_instr_retired;
    logic [1:0]  o_alu_src_a, o_alu_src_b, o_alu_op, o_result_src;
    logic [3:0]  o_state;
    logic [31:0] o_retired_count;

    logic [6:0]  w_stb;
    logic [7:0]  w_sel;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control_unit #(.MEM_TIMEOUT(4), .RETIRE_CNT_W(32)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_opcode        (i_opcode),
        .i_branch_taken  (i_branch_taken),
        .i_mem_ready     (i_mem_ready),
        .o_mem_req       (o_mem_req),
        .o_mem_we        (o_mem_we),
        .o_addr_sel      (o_addr_sel),
        .o_ir_write      (o_ir_write),
        .o_pc_write      (o_pc_write),
        .o_reg_write     (o_reg_write),
        .o_alu_src_a     (o_alu_src_a),
        .o_alu_src_b     (o_alu_src_b),
        .o_alu_op        (o_alu_op),
        .o_result_src    (o_result_src),
        .o_state         (o_state),
        .o_trap          (o_trap),
        .o_trap_cause    (o_trap_cause),
        .o_instr_retired (o_instr_retired),
        .o_retired_count (o_retired_count)
    );

    always #5 i_clk = ~i_clk;

    assign w_stb = {o_mem_req, o_mem_we, o_addr_sel, o_ir_write, o_pc_write,
                    o_reg_write, o_instr_retired};
    assign w_sel = {o_alu_src_a, o_alu_src_b, o_alu_op, o_result_src};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Settle 1ns after the last input change, then check one cycle.
    task automatic chk_cyc(input string tag, input logic [3:0] st,
                           input logic [6:0] stb, input logic [7:0] sel);
        #1;
        chk({tag, ".state"}, 32'(o_state), 32'(st));
        chk({tag, ".stb"},   32'(w_stb),   32'(stb));
        chk({tag, ".sel"},   32'(w_sel),   32'(sel));
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset = 1'b1; i_opcode = 7'b0110011; i_branch_taken = 1'b0;
        i_mem_ready = 1'b1;
        tick();
        // reset held: FETCH would drive req/ir_write, all gated low
        chk_cyc("rst_hold", 4'd0, 7'b0000000, 8'b00000000);
        chk("rst_cnt", o_retired_count, 32'd0);
        chk("rst_trap", 32'({o_trap, o_trap_cause}), 32'd0);
        i_reset = 1'b0;

        // R-type, zero-wait: 0,1,6,8,0
        chk_cyc("r_fetch",  4'd0, 7'b1001100, 8'b00100010); tick();
        chk_cyc("r_decode", 4'd1, 7'b0000000, 8'b01010000); tick();
        chk_cyc("r_exec",   4'd6, 7'b0000000, 8'b10001000); tick();
        chk_cyc("r_aluwb",  4'd8, 7'b0000011, 8'b00000000); tick();
        chk("r_cnt", o_retired_count, 32'd1);

        // Load with 3 wait cycles in MEMREAD (last wait hits the watchdog edge)
        i_opcode = 7'b0000011;
        chk_cyc("ld_fetch",  4'd0, 7'b1001100, 8'b00100010); tick();
        i_mem_ready = 1'b0;
        chk_cyc("ld_decode", 4'd1, 7'b0000000, 8'b01010000); tick();
        chk_cyc("ld_memadr", 4'd2, 7'b0000000, 8'b10010000); tick();
        chk_cyc("ld_wait0",  4'd3, 7'b1010000, 8'b00000000); tick();
        chk_cyc("ld_wait1",  4'd3, 7'b1010000, 8'b00000000); tick();
        chk_cyc("ld_wait2",  4'd3, 7'b1010000, 8'b00000000); tick();
        i_mem_ready = 1'b1;
        chk_cyc("ld_xfer",   4'd3, 7'b1010000, 8'b00000000); tick();
        chk_cyc("ld_memwb",  4'd4, 7'b0000011, 8'b00000001); tick();
        chk("ld_cnt", o_retired_count, 32'd2);

        // Branch taken, then not taken
        i_opcode = 7'b1100011; i_branch_taken = 1'b1;
        chk_cyc("bt_fetch",  4'd0, 7'b1001100, 8'b00100010); tick();
        chk_cyc("bt_decode", 4'd1, 7'b0000000, 8'b01010000); tick();
        chk_cyc("bt_branch", 4'd9, 7'b0000101, 8'b10000100); tick();
        i_branch_taken = 1'b0;
        chk_cyc("bn_fetch",  4'd0, 7'b1001100, 8'b00100010); tick();
        chk_cyc("bn_decode", 4'd1, 7'b0000000, 8'b01010000); tick();
        chk_cyc("bn_branch", 4'd9, 7'b0000001, 8'b10000100); tick();
        chk("br_cnt", o_retired_count, 32'd4);

        // JAL
        i_opcode = 7'b1101111;
        chk_cyc("jal_fetch",  4'd0,  7'b1001100, 8'b00100010); tick();
        chk_cyc("jal_decode", 4'd1,  7'b0000000, 8'b01010000); tick();
        chk_cyc("jal_jump",   4'd10, 7'b0000100, 8'b01010010); tick();
        chk_cyc("jal_link",   4'd12, 7'b0000011, 8'b01100010); tick();
        chk("jal_cnt", o_retired_count, 32'd5);

        // I-type
        i_opcode = 7'b0010011;
        chk_cyc("i_fetch",  4'd0, 7'b1001100, 8'b00100010); tick();
        chk_cyc("i_decode", 4'd1, 7'b0000000, 8'b01010000); tick();
        chk_cyc("i_exec",   4'd7, 7'b0000000, 8'b10011100); tick();
        chk_cyc("i_aluwb",  4'd8, 7'b0000011, 8'b00000000); tick();

        // JALR
        i_opcode = 7'b1100111;
        chk_cyc("jr_fetch",  4'd0,  7'b1001100, 8'b00100010); tick();
        chk_cyc("jr_decode", 4'd1,  7'b0000000, 8'b01010000); tick();
        chk_cyc("jr_jalr",   4'd11, 7'b0000100, 8'b10010010); tick();
        chk_cyc("jr_link",   4'd12, 7'b0000011, 8'b01100010); tick();
        chk("jr_cnt", o_retired_count, 32'd7);

        // Store, zero-wait: retires in MEMWRITE
        i_opcode = 7'b0100011;
        chk_cyc("st_fetch",  4'd0, 7'b1001100, 8'b00100010); tick();
        chk_cyc("st_decode", 4'd1, 7'b0000000, 8'b01010000); tick();
        chk_cyc("st_memadr", 4'd2, 7'b0000000, 8'b10010000); tick();
        chk_cyc("st_write",  4'd5, 7'b1110001, 8'b00000000); tick();
        chk_cyc("st_done",   4'd0, 7'b1001100, 8'b00100010);
        chk("st_cnt", o_retired_count, 32'd8);

        // Store aborted by reset during the MEMWRITE wait
        tick();
        chk_cyc("sa_decode", 4'd1, 7'b0000000, 8'b01010000); tick();
        i_mem_ready = 1'b0;
        chk_cyc("sa_memadr", 4'd2, 7'b0000000, 8'b10010000); tick();
        chk_cyc("sa_wait0",  4'd5, 7'b1110000, 8'b00000000); tick();
        i_reset = 1'b1;
        chk_cyc("sa_rstgate", 4'd5, 7'b0000000, 8'b00000000); tick();
        chk("sa_state", 32'(o_state), 32'd0);
        chk("sa_we", 32'(o_mem_we), 32'd0);
        chk("sa_cnt", o_retired_count, 32'd0);
        i_reset = 1'b0;

        // Illegal opcode (LUI is not supported) -> TRAP cause 0
        i_opcode = 7'b0110111; i_mem_ready = 1'b1;
        chk_cyc("ill_fetch",  4'd0, 7'b1001100, 8'b00100010); tick();
        chk_cyc("ill_decode", 4'd1, 7'b0000000, 8'b01010000);
        chk("ill_pretrap", 32'(o_trap), 32'd0); tick();
        chk_cyc("ill_trap",  4'd15, 7'b0000000, 8'b00000000);
        chk("ill_flags", 32'({o_trap, o_trap_cause}), 32'b10); tick();
        chk_cyc("ill_hold",  4'd15, 7'b0000000, 8'b00000000);
        chk("ill_flags2", 32'({o_trap, o_trap_cause}), 32'b10);
        i_reset = 1'b1; tick();
        i_reset = 1'b0;

        // FETCH timeout: 4 waiting cycles then TRAP cause 1
        i_mem_ready = 1'b0; i_opcode = 7'b0110011;
        chk("to_clear", 32'({o_trap, o_trap_cause}), 32'd0);
        chk_cyc("to_w0", 4'd0, 7'b1000000, 8'b00100010); tick();
        chk_cyc("to_w1", 4'd0, 7'b1000000, 8'b00100010); tick();
        chk_cyc("to_w2", 4'd0, 7'b1000000, 8'b00100010); tick();
        chk_cyc("to_w3", 4'd0, 7'b1000000, 8'b00100010); tick();
        i_mem_ready = 1'b1;
        chk_cyc("to_trap", 4'd15, 7'b0000000, 8'b00000000);
        chk("to_flags", 32'({o_trap, o_trap_cause}), 32'b11); tick();
        chk_cyc("to_hold", 4'd15, 7'b0000000, 8'b00000000);
        chk("to_cnt", o_retired_count, 32'd0);

        i_reset = 1'b1; tick();
        i_reset = 1'b0;
        chk("rel_flags", 32'({o_trap, o_trap_cause}), 32'd0);
        chk("rel_state", 32'(o_state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
